vga_draw_arbiter: RTL and testbench

//  Shares the single VGA plot port between N draw engines (maze, special boxes,

---
 rtl/vga_draw_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// vga_draw_arbiter
//   Shares one VGA plot port between N draw engines. Round-robin grant with
//   exactly one engine enabled at a time; the granted engine's pixel stream
//   is registered onto the VGA port and its requester gets a one-cycle ack.
//
// Ports
//   clk, resetn           clock, synchronous active-low reset
//   req[N]                level request per client; held until its ack
//   draw_en[N]            one-hot level enable to the granted client
//   cl_done[N]            client done flags (only the granted one is looked at)
//   cl_x/cl_y/cl_colour   packed client pixel buses, client i at [i*W +: W]
//   vga_x/y/colour/plot   registered pixel write to the VGA adapter
//   ack[N]                one-cycle pulse when client i's request is served
//   busy                  high whenever the FSM is not IDLE
//   err                   sticky, set when a grant is forcibly released
//   o_dbg_state           current FSM state (IDLE=0, DRAW=1, RELEASE=2)
//
// Handshake: req[i] is a level held by the requester until ack[i] pulses.
// A grant raises draw_en[i] and keeps it high until cl_done[i] is seen (or
// the timeout fires); the ack pulse coincides with draw_en dropping. A req
// dropped before it is granted is simply forgotten; once granted the draw
// always runs to completion and is acked.
// ---------------------------------------------------------------------------
module vga_draw_arbiter #(
  parameter int N       = 4,
  parameter int XW      = 9,
  parameter int YW      = 9,
  parameter int CW      = 3,
  parameter int TIMEOUT = 20000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    draw_en,
  input  logic [N-1:0]    cl_done,
  input  logic [N*XW-1:0] cl_x,
  input  logic [N*YW-1:0] cl_y,
  input  logic [N*CW-1:0] cl_colour,
  output logic [XW-1:0]   vga_x,
  output logic [YW-1:0]   vga_y,
  output logic [CW-1:0]   vga_colour,
  output logic            vga_plot,
  output logic [N-1:0]    ack,
  output logic            busy,
  output logic            err,
  output logic [1:0]      o_dbg_state
);

  localparam int IW = $clog2(N);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRAW    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_cur;
  logic [IW-1:0]   r_rr_ptr;
  logic [TW-1:0]   r_timer;
  logic [N-1:0]    r_draw_en;
  logic [N-1:0]    r_ack;
  logic [XW-1:0]   r_vga_x;
  logic [YW-1:0]   r_vga_y;
  logic [CW-1:0]   r_vga_colour;
  logic            r_vga_plot;
  logic            r_err;

  // Round-robin pick: first requesting client at or after r_rr_ptr, wrapping
  // mod N. Scanning k from high to low lets the smallest offset win.
  logic [IW:0]     w_sum;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_pick;

  always_comb begin
    w_sum  = '0;
    w_idx  = '0;
    w_pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_idx = w_sum[IW-1:0];
      if (req[w_idx]) w_pick = w_idx;
    end
  end

  // Granted client's pixel bus.
  logic [XW-1:0] w_cur_x;
  logic [YW-1:0] w_cur_y;
  logic [CW-1:0] w_cur_colour;
  logic          w_cur_done;
  logic [IW-1:0] w_next_ptr;
  logic          w_timeout;

  assign w_cur_x      = cl_x[r_cur*XW +: XW];
  assign w_cur_y      = cl_y[r_cur*YW +: YW];
  assign w_cur_colour = cl_colour[r_cur*CW +: CW];
  assign w_cur_done   = cl_done[r_cur];
  assign w_next_ptr   = (r_cur == IW'(N - 1)) ? '0 : r_cur + IW'(1);
  assign w_timeout    = (r_timer == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_rr_ptr     <= '0;
      r_timer      <= '0;
      r_draw_en    <= '0;
      r_ack        <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_vga_plot   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          r_vga_plot <= 1'b0;
          if (|req) begin
            r_cur     <= w_pick;
            r_draw_en <= ONE_HOT0 << w_pick;
            r_timer   <= '0;
            r_state   <= S_DRAW;
          end
        end

        S_DRAW: begin
          r_vga_x      <= w_cur_x;
          r_vga_y      <= w_cur_y;
          r_vga_colour <= w_cur_colour;
          // A done client outputs junk, so a done cycle never plots.
          r_vga_plot   <= ~w_cur_done;
          if (w_cur_done || w_timeout) begin
            r_draw_en <= '0;
            r_ack     <= ONE_HOT0 << r_cur;
            r_state   <= S_RELEASE;
            if (!w_cur_done) r_err <= 1'b1;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end

        S_RELEASE: begin
          r_vga_plot <= 1'b0;
          r_rr_ptr   <= w_next_ptr;
          r_timer    <= '0;
          r_state    <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign draw_en     = r_draw_en;
  assign ack         = r_ack;
  assign vga_x       = r_vga_x;
  assign vga_y       = r_vga_y;
  assign vga_colour  = r_vga_colour;
  assign vga_plot    = r_vga_plot;
  assign err         = r_err;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_draw_arbiter
//   Drives N behavioural draw clients and a game-side requester. Every pixel
//   a client presents while granted and not done is pushed to exp_q; each
//   vga_plot seen one cycle later pops and compares it. TIMEOUT is set to 100
//   so that both the 81-pixel draw and the forced-release case fit one DUT.
// ---------------------------------------------------------------------------
module tb_vga_draw_arbiter;

  localparam int N  = 4;
  localparam int XW = 9;
  localparam int YW = 9;
  localparam int CW = 3;
  localparam int TO = 100;
  localparam int PW = XW + YW + CW;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req;
  logic [N-1:0]    draw_en;
  logic [N-1:0]    cl_done;
  logic [N*XW-1:0] cl_x;
  logic [N*YW-1:0] cl_y;
  logic [N*CW-1:0] cl_colour;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_colour;
  logic            vga_plot;
  logic [N-1:0]    ack;
  logic            busy;
  logic            err;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  vga_draw_arbiter #(
    .N(N), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .draw_en(draw_en),
    .cl_done(cl_done), .cl_x(cl_x), .cl_y(cl_y), .cl_colour(cl_colour),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .ack(ack), .busy(busy), .err(err),
    .o_dbg_state(dbg_state)
  );

  // ---------------- scoreboard / bookkeeping ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [PW-1:0] exp_q[$];
  int          grant_log[$];
  int          plot_cnt;
  int          ack_cnt[N];
  int          draw_cycles[N];
  int          len[N];
  int          cnt[N];
  bit          stale[N];
  logic [N-1:0] prev_draw_en = '0;
  logic [N-1:0] prev_ack     = '0;

  task automatic clear_stats();
    plot_cnt = 0;
    grant_log.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      ack_cnt[i]     = 0;
      draw_cycles[i] = 0;
    end
  endtask

  // One clock: observe DUT outputs at the falling edge, then drive the
  // client models for the next rising edge.
  task automatic step();
    logic [PW-1:0] exp;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [CW-1:0] pc;
    logic [N-1:0]  last_en;
    int            depth;
    @(negedge clk);

    if (vga_plot === 1'b1) begin
      plot_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL plot_unexpected: got x=%0d y=%0d c=%0d, required no plot",
                 vga_x, vga_y, vga_colour);
      end else begin
        depth = exp_q.size();
        exp   = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== exp || depth != 1) begin
          n_errors++;
          $display("FAIL plot_data: got %h required %h (pending %0d, required 1)",
                   {vga_x, vga_y, vga_colour}, exp, depth);
        end
      end
    end

    n_checks++;
    if ($countones(draw_en) > 1) begin
      n_errors++;
      $display("FAIL draw_en_onehot: got %b required at most one bit", draw_en);
    end

    if (ack !== '0) begin
      n_checks++;
      if ($countones(ack) != 1 || prev_ack !== '0 || draw_en !== '0) begin
        n_errors++;
        $display("FAIL ack_pulse: got ack=%b prev=%b draw_en=%b, required single 1-cycle bit with draw_en=0",
                 ack, prev_ack, draw_en);
      end
      for (int i = 0; i < N; i++) if (ack[i]) ack_cnt[i]++;
    end

    if (draw_en != '0 && prev_draw_en == '0)
      for (int i = 0; i < N; i++) if (draw_en[i]) grant_log.push_back(i);
    for (int i = 0; i < N; i++) if (draw_en[i]) draw_cycles[i]++;

    last_en      = prev_draw_en;
    prev_draw_en = draw_en;
    prev_ack     = ack;

    // Client models.
    for (int i = 0; i < N; i++) begin
      if (draw_en[i]) begin
        if (stale[i]) begin
          cl_done[i] = 1'b1;
        end else if (cnt[i] < len[i]) begin
          px = XW'($urandom_range(0, (1 << XW) - 1));
          py = YW'($urandom_range(0, (1 << YW) - 1));
          pc = CW'($urandom_range(0, (1 << CW) - 1));
          cl_x[i*XW +: XW]      = px;
          cl_y[i*YW +: YW]      = py;
          cl_colour[i*CW +: CW] = pc;
          cl_done[i] = 1'b0;
          cnt[i]++;
          exp_q.push_back({px, py, pc});
        end else begin
          cl_x[i*XW +: XW]      = '0;
          cl_y[i*YW +: YW]      = '0;
          cl_colour[i*CW +: CW] = '0;
          cl_done[i] = 1'b1;
        end
      end else begin
        if (last_en[i]) stale[i] = 1'b0;
        cnt[i]     = 0;
        cl_done[i] = stale[i];
      end
    end
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Wait (bounded) for ack[idx]; the requester then drops req[idx].
  task automatic wait_ack(input int idx, input int budget, input string name);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (ack[idx] !== 1'b1 && k < budget);
    n_checks++;
    if (ack[idx] !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: got no ack[%0d] within %0d cycles, required a pulse", name, idx, budget);
    end
    req[idx] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    req    = '1;
    settle(2);
    n_checks++;
    if ({draw_en, vga_plot, ack, err, busy} !== '0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got draw_en=%b plot=%b ack=%b err=%b busy=%b, required all 0",
               draw_en, vga_plot, ack, err, busy);
    end
    n_checks++;
    if ({vga_x, vga_y, vga_colour} !== '0) begin
      n_errors++;
      $display("FAIL reset_pixel: got %h required 0", {vga_x, vga_y, vga_colour});
    end
    req    = '0;
    resetn = 1'b1;
    settle(2);
    n_checks++;
    if (busy !== 1'b0 || draw_en !== '0) begin
      n_errors++;
      $display("FAIL idle_no_req: got busy=%b draw_en=%b, required 0/0", busy, draw_en);
    end
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    bit ok;
    clear_stats();
    for (int i = 0; i < N; i++) len[i] = 3;
    req = '1;
    for (int k = 0; k < 200 && grant_log.size() < 5; k++) step();
    req = '0;
    wait_ack(0, 50, "rr_last_ack");
    settle(2);
    ok = (grant_log.size() == 5);
    for (int i = 0; i < 5; i++) if (ok && grant_log[i] != exp_g[i]) ok = 0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL rr_order: got %p required %p", grant_log, exp_g);
    end
    n_checks++;
    if (ack_cnt[0] != 2 || ack_cnt[1] != 1 || ack_cnt[2] != 1 || ack_cnt[3] != 1) begin
      n_errors++;
      $display("FAIL rr_acks: got %p required '{2,1,1,1}", ack_cnt);
    end
    n_checks++;
    if (plot_cnt != 15 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rr_plots: got plots=%0d busy=%b, required 15/0", plot_cnt, busy);
    end
  endtask

  task automatic test_single();
    clear_stats();
    len[1] = 81;
    req    = 4'b0010;
    wait_ack(1, 200, "single_ack");
    settle(2);
    n_checks++;
    if (grant_log.size() != 1 || grant_log[0] != 1) begin
      n_errors++;
      $display("FAIL single_grant: got %p required '{1}", grant_log);
    end
    n_checks++;
    if (plot_cnt != 81 || draw_cycles[1] != 82) begin
      n_errors++;
      $display("FAIL single_plots: got plots=%0d draw_cycles=%0d, required 81/82",
               plot_cnt, draw_cycles[1]);
    end
    n_checks++;
    if (ack_cnt[1] != 1 || busy !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL single_end: got acks=%0d busy=%b pending=%0d, required 1/0/0",
               ack_cnt[1], busy, exp_q.size());
    end
  endtask

  task automatic test_fairness();
    clear_stats();
    len[0] = 2;
    len[2] = 2;
    req    = 4'b0100;
    wait_ack(2, 50, "fair_first_ack");
    req    = 4'b0101;
    wait_ack(0, 50, "fair_ack0");
    wait_ack(2, 50, "fair_ack2");
    settle(2);
    n_checks++;
    if (grant_log.size() != 3 || grant_log[0] != 2 || grant_log[1] != 0 || grant_log[2] != 2) begin
      n_errors++;
      $display("FAIL fairness_order: got %p required '{2,0,2}", grant_log);
    end
    n_checks++;
    if (plot_cnt != 6) begin
      n_errors++;
      $display("FAIL fairness_plots: got %0d required 6", plot_cnt);
    end
  endtask

  task automatic test_timeout();
    clear_stats();
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_before_timeout: got %b required 0", err);
    end
    len[1] = 100000;
    req    = 4'b0010;
    wait_ack(1, 300, "timeout_ack");
    settle(2);
    n_checks++;
    if (draw_cycles[1] != TO || plot_cnt != TO) begin
      n_errors++;
      $display("FAIL timeout_len: got draw_cycles=%0d plots=%0d, required %0d/%0d",
               draw_cycles[1], plot_cnt, TO, TO);
    end
    n_checks++;
    if (err !== 1'b1 || ack_cnt[1] != 1) begin
      n_errors++;
      $display("FAIL timeout_err: got err=%b acks=%0d, required 1/1", err, ack_cnt[1]);
    end
    clear_stats();
    len[1] = 4;
    req    = 4'b0010;
    wait_ack(1, 50, "after_timeout_ack");
    settle(2);
    n_checks++;
    if (err !== 1'b1 || plot_cnt != 4 || grant_log.size() != 1) begin
      n_errors++;
      $display("FAIL after_timeout: got err=%b plots=%0d grants=%0d, required 1/4/1",
               err, plot_cnt, grant_log.size());
    end
  endtask

  task automatic test_stale_done();
    clear_stats();
    stale[3]   = 1'b1;
    cl_done[3] = 1'b1;
    len[3]     = 5;
    settle(2);
    req = 4'b1000;
    wait_ack(3, 50, "stale_ack");
    settle(3);
    n_checks++;
    if (draw_cycles[3] != 1 || plot_cnt != 0) begin
      n_errors++;
      $display("FAIL stale_done: got draw_cycles=%0d plots=%0d, required 1/0",
               draw_cycles[3], plot_cnt);
    end
    n_checks++;
    if (ack_cnt[3] != 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stale_ack_count: got acks=%0d busy=%b, required 1/0", ack_cnt[3], busy);
    end
  endtask

  task automatic test_reset_mid_draw();
    clear_stats();
    len[0] = 50;
    req    = 4'b0001;
    for (int k = 0; k < 20 && draw_cycles[0] < 5; k++) step();
    resetn = 1'b0;
    req    = '0;
    step();
    n_checks++;
    if (draw_en !== '0 || busy !== 1'b0 || vga_plot !== 1'b0 || err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_draw: got draw_en=%b busy=%b plot=%b err=%b, required 0",
               draw_en, busy, vga_plot, err);
    end
    exp_q.delete();
    step();
    resetn = 1'b1;
    settle(5);
    n_checks++;
    if (ack_cnt[0] != 0 || draw_cycles[0] < 5) begin
      n_errors++;
      $display("FAIL reset_no_ack: got acks=%0d draw_cycles=%0d, required 0 acks after >=5 draw cycles",
               ack_cnt[0], draw_cycles[0]);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    resetn    = 1'b0;
    req       = '0;
    cl_done   = '0;
    cl_x      = '0;
    cl_y      = '0;
    cl_colour = '0;
    for (int i = 0; i < N; i++) begin
      len[i]   = 0;
      cnt[i]   = 0;
      stale[i] = 1'b0;
    end
    clear_stats();

    test_reset();
    test_round_robin();
    test_single();
    test_fairness();
    test_timeout();
    test_stale_done();
    test_reset_mid_draw();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL leftover_pixels: got %0d pending, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
